// File: rtl/nes_joypad_serializer.sv
// NES $4016/$4017 controller port: resynchronises the USB button word, emulates the
// 4021 latch/shift register and converts a long reset-button hold into a reset pulse.
module nes_joypad_serializer #(
  parameter int unsigned C_clk_hz             = 25000000,
  parameter int unsigned C_reset_hold_ms      = 500,
  parameter int unsigned C_reset_pulse_cycles = 16,
  parameter logic        C_fill_bit           = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [8:0] i_btn,
  input  logic       i_strobe,
  input  logic       i_read,
  output logic       o_data,
  output logic [8:0] o_btn_sync,
  output logic       o_reset
);

  localparam int unsigned N  = C_clk_hz / 1000 * C_reset_hold_ms;
  localparam int          CW = $clog2(N + 1);
  localparam int          PW = $clog2(C_reset_pulse_cycles + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(N - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(C_reset_pulse_cycles - 1);

  typedef enum logic [1:0] {IDLE, COUNT, FIRE, WAIT_RELEASE} state_t;

  logic [8:0]    sync1_q, sync2_q, prev_q, btn_sync_q, btn_sync_d;
  logic          strobe_q;
  logic [7:0]    sr_q, sr_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          reset_q;
  logic          latch;

  // The word is only accepted once two consecutive synchronised samples agree,
  // so a multi-bit change caught mid-transition never reaches the core.
  always_comb begin
    btn_sync_d = btn_sync_q;
    if (sync2_q == prev_q) btn_sync_d = sync2_q;
  end

  // A read landing on the strobe falling edge still sees the latch as open.
  assign latch = i_strobe | strobe_q;

  always_comb begin
    sr_d = sr_q;
    if (latch)       sr_d = btn_sync_q[7:0];
    else if (i_read) sr_d = {C_fill_bit, sr_q[7:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (btn_sync_q[8]) begin
          state_d = COUNT;
          cnt_d   = '0;
        end
      end
      COUNT: begin
        if (!btn_sync_q[8]) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = FIRE;
          cnt_d   = '0;
          pcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        if (pcnt_q == PULSE_LAST) state_d = WAIT_RELEASE;
        else                      pcnt_d  = pcnt_q + 1'b1;
      end
      WAIT_RELEASE: begin
        if (!btn_sync_q[8]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      btn_sync_q <= '0;
      strobe_q   <= 1'b0;
      sr_q       <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      pcnt_q     <= '0;
      reset_q    <= 1'b0;
    end else begin
      sync1_q    <= i_btn;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      btn_sync_q <= btn_sync_d;
      strobe_q   <= i_strobe;
      sr_q       <= sr_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pcnt_q     <= pcnt_d;
      reset_q    <= (state_d == FIRE);
    end
  end

  assign o_data     = sr_q[0];
  assign o_btn_sync = btn_sync_q;
  assign o_reset    = reset_q;

endmodule

// File: tb/tb_nes_joypad_serializer.sv
// Randomised bench for nes_joypad_serializer: serial reads scored against a latched-word
// model via a queue; CDC filter and reset-button timing checked directly.
module tb_nes_joypad_serializer;

  localparam logic FILL    = 1'b1;
  localparam int   N_HOLD  = 100;
  localparam int   P_CYC   = 16;
  // 4 clocks of resync/filter, 1 clock to leave IDLE, N clocks of counting
  localparam int   RISE_AT = 4 + 1 + N_HOLD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] btn;
  logic       strobe, rd;
  logic       o_data, o_reset;
  logic [8:0] o_btn_sync;

  int   tests = 0, fails = 0;
  bit   exp_q[$];
  logic rd_edge = 1'b0;
  logic e_bit;

  logic [7:0] word;
  int         idx;
  bit         strobe_fell;

  always #5 clk = ~clk;

  nes_joypad_serializer #(
    .C_clk_hz(100000), .C_reset_hold_ms(1),
    .C_reset_pulse_cycles(P_CYC), .C_fill_bit(FILL)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn), .i_strobe(strobe), .i_read(rd),
    .o_data(o_data), .o_btn_sync(o_btn_sync), .o_reset(o_reset)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every read pulse produces one serial bit, visible the clock after.
  always @(posedge clk) rd_edge <= rd;
  always @(negedge clk) begin
    if (rd_edge && rst_n) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: read seen with no expected bit queued");
      end else begin
        e_bit = exp_q.pop_front();
        check("serial_bit", {31'd0, o_data}, {31'd0, e_bit});
        $display("[TB] read: o_data=%0b expected=%0b", o_data, e_bit);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    strobe_fell = 1'b0;
  endtask

  // Reference: a read while the latch is open returns A; otherwise it advances to the
  // next button, and past the 8th button the pad returns the fill value.
  task automatic do_read();
    bit e;
    if (strobe || strobe_fell) begin
      idx = 0;
      e   = word[0];
    end else begin
      idx++;
      e = (idx < 8) ? word[idx] : FILL;
    end
    exp_q.push_back(e);
    rd = 1'b1;
    step();
    rd = 1'b0;
  endtask

  task automatic latch_word(input logic [8:0] v);
    btn = v;
    repeat (6) step();
    strobe = 1'b1;
    word   = v[7:0];
    idx    = 0;
    step();
    step();
    strobe      = 1'b0;
    strobe_fell = 1'b1;
  endtask

  task automatic measure_pulse(output int rise, output int width);
    rise = 0;
    while (!o_reset && rise < 400) begin
      step();
      rise++;
    end
    width = 0;
    while (o_reset && width < 100) begin
      step();
      width++;
    end
  endtask

  initial begin
    int   rise, width, nreads;
    bit   seen;
    rst_n = 1'b0; btn = '0; strobe = 1'b0; rd = 1'b0;
    word = '0; idx = 0; strobe_fell = 1'b0;
    repeat (3) step();
    check("rst_o_data", {31'd0, o_data}, 32'd0);
    check("rst_btn_sync", {23'd0, o_btn_sync}, 32'd0);
    check("rst_o_reset", {31'd0, o_reset}, 32'd0);
    rst_n = 1'b1;
    step();

    // A alone: 1 then seven 0s, then fill bits
    latch_word(9'h001);
    step();
    repeat (10) do_read();

    // U/D/L/R with the buttons released mid-sequence
    latch_word(9'h0F0);
    step();
    repeat (3) do_read();
    btn = 9'h000;
    repeat (5) do_read();

    // Latch held open: reads never shift
    btn = 9'h001;
    repeat (6) step();
    strobe = 1'b1;
    word   = 8'h01;
    repeat (5) do_read();
    strobe      = 1'b0;
    strobe_fell = 1'b1;
    step();

    // Coherency filter: a word changing every clock must never be accepted
    btn = 9'h000;
    repeat (6) step();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      btn = (i % 2 == 0) ? 9'h1FF : 9'h000;
      step();
      if (o_btn_sync != 9'h000) seen = 1'b1;
    end
    check("cdc_toggle_no_update", {31'd0, seen}, 32'd0);
    btn = 9'h003;
    repeat (3) step();
    check("cdc_not_before_4", {31'd0, (o_btn_sync == 9'h003)}, 32'd0);
    step();
    check("cdc_latency_4", {23'd0, o_btn_sync}, 32'h003);

    // Randomised frames, including reads on the strobe falling edge
    for (int it = 0; it < 25; it++) begin
      latch_word(9'($urandom));
      nreads = $urandom_range(0, 11);
      for (int r = 0; r < nreads; r++) begin
        if ($urandom_range(0, 3) == 0) btn = 9'($urandom);
        repeat ($urandom_range(0, 2)) step();
        do_read();
      end
      $display("[TB] frame %0d: word=%02h reads=%0d", it, word, nreads);
    end
    repeat (3) step();
    check("sb_drained", exp_q.size(), 32'd0);

    // Reset button timing
    rst_n = 1'b0; btn = '0;
    step();
    rst_n = 1'b1;
    repeat (6) step();

    btn  = 9'h100;
    seen = 1'b0;
    repeat (N_HOLD - 1) begin step(); if (o_reset) seen = 1'b1; end
    btn = 9'h000;
    repeat (10) begin step(); if (o_reset) seen = 1'b1; end
    check("hold_99_no_reset", {31'd0, seen}, 32'd0);

    btn = 9'h100;
    measure_pulse(rise, width);
    check("press1_rise", rise, RISE_AT);
    check("press1_width", width, P_CYC);
    $display("[TB] press1: rise=%0d width=%0d", rise, width);
    seen = 1'b0;
    repeat (200) begin step(); if (o_reset) seen = 1'b1; end
    check("held_no_repeat", {31'd0, seen}, 32'd0);
    btn = 9'h000;
    repeat (10) step();

    btn  = 9'h100;
    seen = 1'b0;
    repeat (50) begin step(); if (o_reset) seen = 1'b1; end
    btn = 9'h000;
    repeat (10) begin step(); if (o_reset) seen = 1'b1; end
    check("short_press_no_reset", {31'd0, seen}, 32'd0);

    btn = 9'h100;
    measure_pulse(rise, width);
    check("press2_rise", rise, RISE_AT);
    check("press2_width", width, P_CYC);
    $display("[TB] press2: rise=%0d width=%0d", rise, width);
    btn = 9'h000;
    repeat (10) step();

    // Async reset in the middle of the pulse, button still held
    btn  = 9'h100;
    rise = 0;
    while (!o_reset && rise < 400) begin step(); rise++; end
    check("press3_rise", rise, RISE_AT);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("async_rst_o_reset", {31'd0, o_reset}, 32'd0);
    check("async_rst_btn_sync", {23'd0, o_btn_sync}, 32'd0);
    step();
    rst_n = 1'b1;
    measure_pulse(rise, width);
    check("recount_rise", rise, RISE_AT);
    check("recount_width", width, P_CYC);
    $display("[TB] after reset: rise=%0d width=%0d", rise, width);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
